// File: rtl/rtc_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rtc_wb_pkg
// Description : Shared constants and types for the RTC Wishbone initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_wb_pkg;

    localparam logic [2:0] RTC_CLOCK     = 3'd0;
    localparam logic [2:0] RTC_TIMER     = 3'd1;
    localparam logic [2:0] RTC_STOPWATCH = 3'd2;
    localparam logic [2:0] RTC_ALARM     = 3'd3;
    localparam logic [2:0] RTC_CKSPEED   = 3'd4;
    localparam logic [2:0] RTC_HACK_TIME = 3'd5;
    localparam logic [2:0] RTC_HACK_HI   = 3'd6;
    localparam logic [2:0] RTC_HACK_LO   = 3'd7;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic c_SRC_CMD  = 1'b0;
    localparam logic c_SRC_POLL = 1'b1;

    typedef struct packed {
        logic        we;
        logic [2:0]  adr;
        logic [31:0] dat;
        logic        src;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/rtc_wb_master_poll_timer.sv
`default_nettype none
// ============================================================================
// Module      : rtc_poll_timer
// Description : Free-running poll interval counter with a single pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_poll_timer
    import rtc_wb_pkg::*;
#(
    parameter logic [31:0] POLL_PERIOD = 32'd100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_take,
    output logic o_pend
);

    logic [31:0] r_cnt_q;
    logic [31:0] w_cnt_d;
    logic        r_pend_q;
    logic        w_pend_d;
    logic        w_wrap;

    always_comb begin
        w_wrap   = i_en && (r_cnt_q == POLL_PERIOD - 32'd1);
        w_cnt_d  = '0;
        w_pend_d = 1'b0;
        if (i_en) begin
            w_cnt_d  = w_wrap ? '0 : r_cnt_q + 32'd1;
            // a wrap landing on an already-pending poll is dropped, not queued
            w_pend_d = (r_pend_q && !i_take) || (w_wrap && !r_pend_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q  <= '0;
            r_pend_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_pend_q <= w_pend_d;
        end
    end

    assign o_pend = r_pend_q;

endmodule
`default_nettype wire

// File: rtl/rtc_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : rtc_wb_master
// Description : Single-transfer Wishbone initiator for the RTC register slave
//               with command port and autonomous clock-register polling.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_wb_master
    import rtc_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [31:0] POLL_PERIOD = 32'd100000000,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [2:0]  cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    input  logic        poll_en_i,
    output logic [31:0] poll_time_o,
    output logic        poll_upd_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i
);

    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state_q;
    logic [1:0]  w_state_d;
    req_t        r_req_q;
    req_t        w_req_d;
    logic [15:0] r_tmo_q;
    logic [15:0] w_tmo_d;
    logic        r_err_q;
    logic        w_err_d;
    logic [31:0] r_rsp_dat_q;
    logic [31:0] w_rsp_dat_d;
    logic [31:0] r_poll_time_q;
    logic [31:0] w_poll_time_d;
    logic        w_take_poll;
    logic        w_poll_pend;
    logic        w_in_bus;
    logic        w_in_resp;

    rtc_poll_timer #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_poll_timer (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .i_en   (poll_en_i),
        .i_take (w_take_poll),
        .o_pend (w_poll_pend)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q     <= c_ST_IDLE;
            r_req_q       <= '0;
            r_tmo_q       <= '0;
            r_err_q       <= 1'b0;
            r_rsp_dat_q   <= '0;
            r_poll_time_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_req_q       <= w_req_d;
            r_tmo_q       <= w_tmo_d;
            r_err_q       <= w_err_d;
            r_rsp_dat_q   <= w_rsp_dat_d;
            r_poll_time_q <= w_poll_time_d;
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_req_d       = r_req_q;
        w_tmo_d       = r_tmo_q;
        w_err_d       = r_err_q;
        w_rsp_dat_d   = r_rsp_dat_q;
        w_poll_time_d = r_poll_time_q;
        w_take_poll   = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                w_tmo_d = '0;
                if (cmd_valid_i) begin
                    w_req_d   = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, src: c_SRC_CMD};
                    w_state_d = c_ST_BUS;
                end else if (w_poll_pend) begin
                    w_req_d     = '{we: 1'b0, adr: RTC_CLOCK, dat: 32'd0, src: c_SRC_POLL};
                    w_take_poll = 1'b1;
                    w_state_d   = c_ST_BUS;
                end
            end
            c_ST_BUS: begin
                // ack on the final timeout cycle still counts as success
                if (m_ack_i) begin
                    w_err_d   = 1'b0;
                    w_state_d = c_ST_RESP;
                    if (r_req_q.src == c_SRC_CMD) begin
                        w_rsp_dat_d = r_req_q.we ? 32'd0 : m_dat_i;
                    end else begin
                        w_poll_time_d = m_dat_i;
                    end
                end else if (r_tmo_q == c_TMO_LAST) begin
                    w_err_d   = 1'b1;
                    w_state_d = c_ST_RESP;
                    if (r_req_q.src == c_SRC_CMD) begin
                        w_rsp_dat_d = 32'd0;
                    end
                end else begin
                    w_tmo_d = r_tmo_q + 16'd1;
                end
            end
            c_ST_RESP: w_state_d = c_ST_IDLE;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_bus    = (r_state_q == c_ST_BUS);
        w_in_resp   = (r_state_q == c_ST_RESP) && !wb_rst_i;
        cmd_ready_o = (r_state_q == c_ST_IDLE) && !wb_rst_i;
        m_cyc_o     = w_in_bus;
        m_stb_o     = w_in_bus;
        m_we_o      = w_in_bus && r_req_q.we;
        m_sel_o     = w_in_bus ? 4'hf : 4'h0;
        m_adr_o     = w_in_bus ? {BASE_ADDR[31:3], r_req_q.adr} : 32'd0;
        m_dat_o     = w_in_bus ? r_req_q.dat : 32'd0;
        rsp_valid_o = w_in_resp && (r_req_q.src == c_SRC_CMD);
        rsp_err_o   = rsp_valid_o && r_err_q;
        rsp_dat_o   = r_rsp_dat_q;
        poll_upd_o  = w_in_resp && (r_req_q.src == c_SRC_POLL) && !r_err_q;
        poll_time_o = r_poll_time_q;
    end

endmodule
`default_nettype wire
